// File: rtl/mips_pc_pkg.sv
// Shared types and constants for the MIPS PC sequencer.
package mips_pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    BTGT = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

  // Branch offset in words -> signed byte offset.
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/mips_pc_sequencer_adder.sv
// 32-bit modulo-2^32 adder shared by the PC sequencer.
module MIPS_ADDER (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/mips_pc_sequencer.sv
// PC register and next-fetch sequencing; one adder is time-shared between
// PC+4 (RUN) and branch-target calculation (BTGT).
module mips_pc_sequencer
  import mips_pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_req,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump_req,
  input  logic [25:0] jump_index,
  input  logic        jr_req,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic [31:0] link_addr,
  output logic [31:0] epc,
  output logic        addr_err
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        addr_err_q, addr_err_d;
  logic [31:0] npc_q, npc_d;
  logic [15:0] imm_q, imm_d;

  logic [31:0] add_a, add_b, add_sum;

  // Operand mux: the state decides which job the adder does this cycle.
  always_comb begin
    add_a = pc_q;
    add_b = PC_INC;
    if (state_q == BTGT) begin
      add_a = npc_q;
      add_b = br_offset(imm_q);
    end
  end

  MIPS_ADDER u_adder (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    addr_err_d = 1'b0;
    npc_d      = npc_q;
    imm_d      = imm_q;
    case (state_q)
      BOOT: begin
        pc_d    = RESET_VECTOR;
        state_d = RUN;
      end
      RUN: begin
        if (exc_req) begin
          epc_d = pc_q;
          pc_d  = EXC_VECTOR;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (jr_req) begin
          if (jr_target[1:0] != 2'b00) begin
            addr_err_d = 1'b1;
            epc_d      = pc_q;
            pc_d       = EXC_VECTOR;
          end else begin
            pc_d = jr_target;
          end
        end else if (jump_req) begin
          pc_d = {add_sum[31:28], jump_index, 2'b00};
        end else if (branch_req && branch_taken) begin
          npc_d   = add_sum;
          imm_d   = branch_imm;
          state_d = BTGT;
        end else begin
          pc_d = add_sum;
        end
      end
      BTGT: begin
        if (!stall) begin
          pc_d    = add_sum;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      epc_q      <= 32'd0;
      addr_err_q <= 1'b0;
      npc_q      <= 32'd0;
      imm_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      addr_err_q <= addr_err_d;
      npc_q      <= npc_d;
      imm_q      <= imm_d;
    end
  end

  assign pc        = pc_q;
  assign pc_valid  = (state_q == RUN);
  assign link_addr = add_sum;
  assign epc       = epc_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Directed vectors for mips_pc_sequencer with hand-computed expectations.
module tb_mips_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_req;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump_req;
  logic [25:0] jump_index;
  logic        jr_req;
  logic [31:0] jr_target;
  logic        exc_req;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] link_addr;
  logic [31:0] epc;
  logic        addr_err;

  int n_cmp = 0;
  int n_err = 0;

  mips_pc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_req   (branch_req),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump_req     (jump_req),
    .jump_index   (jump_index),
    .jr_req       (jr_req),
    .jr_target    (jr_target),
    .exc_req      (exc_req),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .link_addr    (link_addr),
    .epc          (epc),
    .addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; branch_req = 0; branch_taken = 0; branch_imm = 16'h0;
    jump_req = 0; jump_index = 26'h0; jr_req = 0; jr_target = 32'h0; exc_req = 0;
  endtask

  task automatic do_jump(input logic [25:0] idx);
    jump_req = 1; jump_index = idx;
    step();
    idle();
  endtask

  task automatic do_jr(input logic [31:0] tgt);
    jr_req = 1; jr_target = tgt;
    step();
    idle();
  endtask

  initial begin
    logic [31:0] seq [4];
    seq = '{32'h0, 32'h4, 32'h8, 32'hC};
    idle();
    reset = 1;
    repeat (3) step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'd0, pc_valid}, 32'd0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_addr_err", {31'd0, addr_err}, 32'd0);

    reset = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("seq_valid", {31'd0, pc_valid}, 32'd1);
      chk("seq_pc", pc, seq[i]);
    end
    chk("link_addr", link_addr, 32'h10);

    // Backward taken branch from 0x40: 0x44 + (-8) = 0x3C
    do_jump(26'h10);
    chk("jmp_pc40", pc, 32'h40);
    branch_req = 1; branch_taken = 1; branch_imm = 16'hFFFE;
    step();
    idle();
    chk("br_bubble_valid", {31'd0, pc_valid}, 32'd0);
    chk("br_bubble_pc", pc, 32'h40);
    step();
    chk("br_tgt_valid", {31'd0, pc_valid}, 32'd1);
    chk("br_tgt_pc", pc, 32'h3C);

    // Not-taken branch
    do_jump(26'h40);
    chk("jmp_pc100", pc, 32'h100);
    branch_req = 1; branch_taken = 0; branch_imm = 16'h1234;
    step();
    idle();
    chk("br_nt_pc", pc, 32'h104);
    chk("br_nt_valid", {31'd0, pc_valid}, 32'd1);

    // Wrap at top of address space
    do_jr(32'hFFFF_FFFC);
    chk("jr_top", pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc", pc, 32'h0);

    // Jump keeps pc4[31:28]
    do_jr(32'h1000_0010);
    chk("jr_pc", pc, 32'h1000_0010);
    do_jump(26'h40);
    chk("jmp_region", pc, 32'h1000_0100);

    // Misaligned JR
    do_jr(32'h0000_0202);
    chk("jr_mis_err", {31'd0, addr_err}, 32'd1);
    chk("jr_mis_epc", epc, 32'h1000_0100);
    chk("jr_mis_pc", pc, 32'h80);
    step();
    chk("addr_err_pulse", {31'd0, addr_err}, 32'd0);
    chk("post_exc_pc", pc, 32'h84);

    // Priority: exc over stall over jump
    do_jump(26'h8);
    chk("jmp_pc20", pc, 32'h20);
    exc_req = 1; stall = 1; jump_req = 1; jump_index = 26'h3FF;
    step();
    idle();
    chk("prio_pc", pc, 32'h80);
    chk("prio_epc", epc, 32'h20);

    stall = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_pc", pc, 32'h80);
      chk("stall_valid", {31'd0, pc_valid}, 32'd1);
    end
    idle();
    step();
    chk("unstall_pc", pc, 32'h84);

    // exc_req in BTGT is ignored: 0x88 + 16 = 0x98
    branch_req = 1; branch_taken = 1; branch_imm = 16'h0004;
    step();
    idle();
    exc_req = 1;
    step();
    idle();
    chk("btgt_exc_pc", pc, 32'h98);
    chk("btgt_exc_epc", epc, 32'h20);

    // Reset mid-branch discards the target
    branch_req = 1; branch_taken = 1; branch_imm = 16'h0010;
    step();
    idle();
    chk("midbr_valid", {31'd0, pc_valid}, 32'd0);
    reset = 1;
    step();
    chk("midbr_rst_pc", pc, 32'h0);
    chk("midbr_rst_valid", {31'd0, pc_valid}, 32'd0);
    chk("midbr_rst_epc", epc, 32'h0);
    reset = 0;
    step();
    chk("midbr_run_pc", pc, 32'h0);
    chk("midbr_run_valid", {31'd0, pc_valid}, 32'd1);
    step();
    chk("midbr_seq_pc", pc, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
